bcd_stopwatch_ctrl: RTL and testbench
=====================================

# bcd_stopwatch_ctrl

Stopwatch controller that sequences a cascaded chain of BCD digit counters from start/stop/clear commands and a divided time-base tick. It sits between debounced user push-button pulses and the seven-segment display driver on the UPduino 3.1 designs. It owns the run/pause state machine, the tick prescaler, digit-to-digit carry sequencing, sticky overflow and an optional lap-freeze display path.

## Interface
- DIGITS, 4: number of BCD digits in the chain, 1..8.
- TICK_DIV, 12000000: clk cycles per count tick, ≥2 (12 MHz clock gives 1 Hz).
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clk edge with reset high fully initialises the block.
- start_stop  in  1  single-cycle command pulse; toggles run/pause.
- clear  in  1  single-cycle command pulse; returns to zero and IDLE.
- lap  in  1  single-cycle command pulse; lap freeze/release (LAP_FREEZE_EN only).
- digits  out  4*DIGITS  live BCD count; digit 0 (least significant) in [3:0].
- display  out  4*DIGITS  value for the display driver: live or frozen lap value.
- running  out  1  high when the state is RUNNING.
- tick  out  1  one-cycle pulse when the chain advances.
- overflow  out  1  sticky; set when the chain wraps from all-9s to all-0s.

## Operation
- States: IDLE, RUNNING, PAUSED. Encoding is free; running = (state==RUNNING).
- Transitions, evaluated each edge in priority order:
  - reset, then clear: go to IDLE; digits=0, prescaler=0, overflow=0, lap hold released.
  - start_stop: IDLE→RUNNING, RUNNING→PAUSED, PAUSED→RUNNING.
  - Otherwise hold the state.
- Prescaler: counts 0..TICK_DIV-1 only in RUNNING. At TICK_DIV-1 it wraps to 0 and asserts tick for that cycle. It holds its value in PAUSED, so the partial interval resumes. It is 0 in IDLE. Width is clog2(TICK_DIV).
- Digit sequencing:
  - On tick, digit 0 increments.
  - Digit i>0 increments on tick when digits 0..i-1 all equal 9.
  - A digit at 9 that increments becomes 0.
  - A digit holding an invalid code >9 is forced to 0 on the next edge regardless of state.
- Overflow: set on the tick where all digits equal 9 (all become 0). It stays set until reset or clear. Counting continues.
- start_stop and a tick in the same cycle: the tick increment still applies, and the state changes on the same edge.
- clear and start_stop together: clear wins and the state is IDLE.

## Timing
- All outputs are registered. Reset values: digits=0, display=0, running=0, tick=0, overflow=0; prescaler=0; state=IDLE.
- start_stop high at edge t: running changes at t+1.
- First tick occurs TICK_DIV cycles after entering RUNNING from IDLE.
- tick is registered and coincident with the updated digits: digits reflect the increment in the same cycle tick is high.
- Carry ripple is resolved in one cycle. No multi-cycle digit propagation.
- clear takes effect on the next edge, even mid-interval or during a tick cycle.

## Configuration
- Macro: LAP_FREEZE_EN.
- Defined:
  - A lap pulse while no hold is active captures digits into a lap register. display shows that register (hold active).
  - A second lap pulse releases the hold; display follows digits again.
  - Counting continues underneath.
  - lap in IDLE is ignored.
  - clear and reset release the hold.
  - A lap capture takes the value of digits before that edge's increment.
- Undefined: lap is ignored, no lap register exists, and display equals digits every cycle.

## Test plan
- Reset/IDLE, TICK_DIV=4, DIGITS=2:
  - Stimulus: assert reset one cycle, then idle 20 cycles.
  - Required: digits=8'h00, running=0, tick never pulses.
- Run:
  - Stimulus: start_stop pulse at cycle 0.
  - Required: running=1 at cycle 1; tick at cycles 4, 8, 12; digits=8'h01, 8'h02, 8'h03.
- Carry and overflow:
  - Stimulus: run 99 ticks, then one more tick.
  - Required: digits=8'h09→8'h10 at tick 10; 8'h99 at tick 99; tick 100 gives 8'h00 with overflow=1, and counting continues.
- Pause/resume:
  - Stimulus: pause 2 cycles after a tick, wait 50 cycles, then resume.
  - Required: digits unchanged while paused; next tick 2 cycles after resume (prescaler preserved).
- Clear priority:
  - Stimulus: clear and start_stop in the same cycle while RUNNING with overflow=1.
  - Required: next cycle state IDLE, digits=0, overflow=0, running=0.
- Lap (LAP_FREEZE_EN):
  - Stimulus: lap at digits=8'h05, run to 8'h09, then lap again.
  - Required: display=8'h05 while held; display=8'h09 after release. Without the macro, display equals digits throughout.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command and status bundle between the push-button front end and the stopwatch controller.
interface bcd_stopwatch_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start_stop;
  logic                  clear;
  logic                  lap;
  logic [4*DIGITS-1:0]   digits;
  logic [4*DIGITS-1:0]   display;
  logic                  running;
  logic                  tick;
  logic                  overflow;

  modport master (
    output start_stop, clear, lap,
    input  digits, display, running, tick, overflow
  );

  modport slave (
    input  start_stop, clear, lap,
    output digits, display, running, tick, overflow
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause stopwatch controller driving a cascaded BCD digit chain from a prescaled tick.
// Optional lap-freeze display path is enabled by defining LAP_FREEZE_EN.
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 12000000
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_stopwatch_ctrl_if.slave   sw
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [W-1:0]   digits_q, digits_d;
  logic [W-1:0]   display_q, display_d;
  logic           running_q, running_d;
  logic           tick_q, tick_d;
  logic           overflow_q, overflow_d;
  logic           carry;
  logic           hold_q, hold_d;
  logic [W-1:0]   lap_q, lap_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      digits_q   <= '0;
      display_q  <= '0;
      running_q  <= 1'b0;
      tick_q     <= 1'b0;
      overflow_q <= 1'b0;
      hold_q     <= 1'b0;
      lap_q      <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      digits_q   <= digits_d;
      display_q  <= display_d;
      running_q  <= running_d;
      tick_q     <= tick_d;
      overflow_q <= overflow_d;
      hold_q     <= hold_d;
      lap_q      <= lap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    digits_d   = digits_q;
    tick_d     = 1'b0;
    overflow_d = overflow_q;
    hold_d     = hold_q;
    lap_d      = lap_q;
    carry      = 1'b0;

    for (int i = 0; i < DIGITS; i++) begin
      if (digits_q[4*i +: 4] > 4'd9) digits_d[4*i +: 4] = 4'd0;
    end

    if (sw.clear) begin
      state_d    = IDLE;
      presc_d    = '0;
      digits_d   = '0;
      overflow_d = 1'b0;
      hold_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (sw.start_stop) state_d = RUNNING;
        RUNNING: if (sw.start_stop) state_d = PAUSED;
        PAUSED:  if (sw.start_stop) state_d = RUNNING;
        default: state_d = IDLE;
      endcase

      // Prescaler advances only while running; a paused partial interval is kept.
      if (state_q == RUNNING) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end else if (state_q == IDLE) begin
        presc_d = '0;
      end

      // Single-cycle ripple: a digit steps when every lower digit is 9.
      if (tick_d) begin
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          if (carry) begin
            if (digits_q[4*i +: 4] >= 4'd9) digits_d[4*i +: 4] = 4'd0;
            else                            digits_d[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
            carry = (digits_q[4*i +: 4] == 4'd9);
          end
        end
        if (carry) overflow_d = 1'b1;
      end

`ifdef LAP_FREEZE_EN
      if (sw.lap && (state_q != IDLE)) begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          hold_d = 1'b1;
          lap_d  = digits_q;
        end
      end
`endif
    end

    running_d = (state_d == RUNNING);
    display_d = hold_d ? lap_d : digits_d;
  end

`ifndef LAP_FREEZE_EN
  logic lap_unused;
  assign lap_unused = sw.lap;
`endif

  assign sw.digits   = digits_q;
  assign sw.display  = display_q;
  assign sw.running  = running_q;
  assign sw.tick     = tick_q;
  assign sw.overflow = overflow_q;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Vector-table and scoreboard bench for bcd_stopwatch_ctrl with DIGITS=2, TICK_DIV=4.
module tb_bcd_stopwatch_ctrl;
  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int W        = 4 * DIGITS;

  typedef struct {
    logic         rst;
    logic         ss;
    logic         clr;
    logic         lap;
    logic [W-1:0] dig;
    logic [W-1:0] disp;
    logic         run;
    logic         tick;
    logic         ov;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  bcd_stopwatch_ctrl_if #(.DIGITS(DIGITS)) sw ();

  bcd_stopwatch_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  vec_t  vecs[$];
  vec_t  expq[$];
  int    vec_count = 0;
  int    miscompares = 0;
  string phase = "init";

  function automatic logic [W-1:0] bcd(input int m);
    logic [W-1:0] r;
    r = {4'((m / 10) % 10), 4'(m % 10)};
    return r;
  endfunction

  function automatic vec_t mk(input logic rst, input logic ss, input logic clr, input logic lap,
                              input logic [W-1:0] dig, input logic run, input logic tick,
                              input logic ov);
    vec_t v;
    v.rst = rst; v.ss = ss; v.clr = clr; v.lap = lap;
    v.dig = dig; v.disp = dig; v.run = run; v.tick = tick; v.ov = ov;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset         = v.rst;
    sw.start_stop = v.ss;
    sw.clear      = v.clr;
    sw.lap        = v.lap;
    expq.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: scoreboard empty at vector %0d", phase, vec_count);
      return;
    end
    e = expq.pop_front();
    vec_count++;
    if (sw.digits !== e.dig || sw.display !== e.disp || sw.running !== e.run ||
        sw.tick !== e.tick || sw.overflow !== e.ov) begin
      miscompares++;
      $display("[TB] FAIL %s vec %0d: got digits=%h display=%h running=%b tick=%b overflow=%b, want digits=%h display=%h running=%b tick=%b overflow=%b",
               phase, vec_count, sw.digits, sw.display, sw.running, sw.tick, sw.overflow,
               e.dig, e.disp, e.run, e.tick, e.ov);
    end
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  initial begin
    vec_t v;
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    sw.lap        = 1'b0;

    // Reset, idle, run three ticks, pause/resume, start_stop on a tick, clear.
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0));
    repeat (20) vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 0, 0));
    for (int n = 0; n < 3; n++) begin
      repeat (3) vecs.push_back(mk(0, 0, 0, 0, bcd(n), 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, bcd(n + 1), 1, 1, 0));
    end
    vecs.push_back(mk(0, 0, 0, 0, 8'h03, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h03, 0, 0, 0));
    repeat (50) vecs.push_back(mk(0, 0, 0, 0, 8'h03, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h03, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h03, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h04, 1, 1, 0));
    repeat (3) vecs.push_back(mk(0, 0, 0, 0, 8'h04, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h05, 0, 1, 0));
    repeat (3) vecs.push_back(mk(0, 0, 0, 0, 8'h05, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0));
    repeat (6) vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0));

    phase = "table";
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Carry through 8'h10, all-9s wrap with sticky overflow, counting continues.
    phase = "carry";
    step(mk(0, 1, 0, 0, 8'h00, 1, 0, 0));
    for (int k = 1; k <= 408; k++) begin
      int n;
      n = k / TICK_DIV;
      step(mk(0, 0, 0, 0, bcd(n % 100), 1, (k % TICK_DIV) == 0, n >= 100));
    end

    phase = "clear_prio";
    step(mk(0, 1, 1, 0, 8'h00, 0, 0, 0));
    repeat (8) step(mk(0, 0, 0, 0, 8'h00, 0, 0, 0));

    // Lap ignored in IDLE, capture at 05, release at 09.
    phase = "lap";
    step(mk(0, 0, 0, 1, 8'h00, 0, 0, 0));
    step(mk(0, 1, 0, 0, 8'h00, 1, 0, 0));
    for (int k = 1; k <= 48; k++) begin
      int n;
      n = k / TICK_DIV;
      v = mk(0, 0, 0, (k == 21 || k == 37 || k == 45), bcd(n), 1, (k % TICK_DIV) == 0, 0);
`ifdef LAP_FREEZE_EN
      if (k >= 21 && k <= 36) v.disp = 8'h05;
      if (k >= 45)            v.disp = 8'h11;
`endif
      step(v);
    end

    // Clear must drop any lap hold so display tracks the live count again.
    phase = "lap_clear";
    step(mk(0, 0, 1, 0, 8'h00, 0, 0, 0));
    step(mk(0, 1, 0, 0, 8'h00, 1, 0, 0));
    for (int k = 1; k <= 8; k++) begin
      step(mk(0, 0, 0, 0, bcd(k / TICK_DIV), 1, (k % TICK_DIV) == 0, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule
